kamus_id_stage: RTL and testbench
=================================

KAMUS_ID_STAGE -- requirements
Module: kamus_id_stage

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32, width of instr_addr_i, next_pc_i and the decoded pc field.
REQ-002 SHALL have parameter DEPTH, default 2, decoded-instruction queue entries; legal values are powers of 2 that are at least 1.
REQ-003 SHALL have parameter MACHINE_MODE_EN, default 0; when 1 it enables MRET, WFI and the machine-mode CSR set.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk_i  in  1  clock.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 flush_i  in  1  discard all queued and incoming instructions.
REQ-008 instr_valid_i  in  1  IF offers an instruction.
REQ-009 instr_ready_o  out  1  stage accepts the offered instruction.
REQ-010 instr_i  in  32  raw instruction.
REQ-011 instr_addr_i  in  PC_WIDTH  instruction PC.
REQ-012 next_pc_i  in  PC_WIDTH  fetch-predicted next PC.
REQ-013 ex_load_valid_i  in  1  a load occupies EX.
REQ-014 ex_load_rd_i  in  5  destination register of that load.
REQ-015 dec_valid_o  out  1  queue head valid toward EX.
REQ-016 dec_ready_i  in  1  EX consumes the head.
REQ-017 dec_o  out  instr_decoded_t  head bundle: operation, opcode, immediate, immediate_used, pc, next_pc, illegal.
REQ-018 rs1_addr_o, rs2_addr_o, rd_addr_o  out  5 each  head register addresses for register-file read.
REQ-019 stall_cnt_o  out  32  saturating count of hazard-stall cycles.
REQ-020 occupancy_o  out  $clog2(DEPTH+1)  number of queued entries.

Function
REQ-021 Decode SHALL be RV32I plus Zicsr, matching the team decode tables; illegal = (operation == INVALID), including opext != 2'b11 and undefined funct3 codes.
REQ-022 Immediates SHALL be sign-extended to 32 bits for I, S, B and J formats and zero-filled low for U format; CSR zimm uses instr[19:15], zero-extended.
REQ-023 Handshake: an instruction transfers when instr_valid_i && instr_ready_o; the head retires when dec_valid_o && dec_ready_i.
REQ-024 instr_ready_o = !full && !hazard && !flush_i.
REQ-025 instr_ready_o SHALL NOT depend on dec_ready_i, so there is no combinational path from dec_ready_i to instr_ready_o; a pop while full frees a slot the next cycle.
REQ-026 Latency: an accepted instruction SHALL appear at the head one cycle later if the queue was empty; order is FIFO.
REQ-027 Simultaneous push and pop when not full SHALL leave occupancy unchanged.
REQ-028 Pointers SHALL wrap modulo DEPTH.
REQ-029 hazard SHALL assert when the offered instruction reads a nonzero rs that matches either ex_load_rd_i while ex_load_valid_i, or the rd of any queued load entry.
REQ-030 rs1 is read by all instructions except LUI, AUIPC, JAL and CSR-immediate forms; rs2 is read by B, S and register ALU instructions.
REQ-031 stall_cnt_o SHALL increment when instr_valid_i && hazard && !flush_i, and SHALL saturate at 0xFFFFFFFF.
REQ-032 flush_i SHALL empty the queue at the next edge, drop the current offer, and force dec_valid_o=0 in the following cycle.
REQ-033 flush_i SHALL take priority over any simultaneous push or pop.
REQ-034 Illegal instructions SHALL be queued normally with illegal=1; trapping is EX's responsibility.
REQ-035 When empty, dec_o and the register addresses SHALL be driven with all-zero values.

Reset
REQ-036 In any cycle with rst_i=1, reset SHALL: empty the queue, clear dec_valid_o, occupancy_o and stall_cnt_o, and drive instr_ready_o=0.
REQ-037 Reset SHALL override flush, push and pop; reset mid-transfer SHALL discard all entries.

Structure
REQ-038 kamus_pkg SHALL hold operation_e, csr_e, the opcode/funct constants, and instr_decoded_t extended with next_pc and illegal.
REQ-039 Combinational decoding SHALL sit in one sub-module, kamus_id_decoder, covering the operation, immediate, register-usage flags and is_load.
REQ-040 The queue and hazard logic SHALL reside in kamus_id_stage.

Verification
REQ-041 Reset, then offer 0x002081B3 (ADD x3,x1,x2) -> next cycle dec_valid_o=1, operation=ADD, rs1=1, rs2=2, rd=3, immediate_used=0.
REQ-042 Offer 0x123450B7 (LUI x1) -> immediate=0x12345000, immediate_used=1; offer 0x00000000 -> illegal=1, operation=INVALID.
REQ-043 Queue 0x0000A283 (LW x5), hold dec_ready_i=0, offer 0x00128313 (ADDI x6,x5,1) -> instr_ready_o=0 and stall_cnt_o increments.
REQ-044 In the same scenario, pop the LW and deassert ex_load_valid_i -> ADDI is accepted.
REQ-045 DEPTH=2, dec_ready_i=0, push 3 instructions -> third offer held, occupancy_o=2; one pop -> third accepted a cycle later, order preserved.
REQ-046 Queue 2 entries, assert flush_i with instr_valid_i=1 -> next cycle occupancy_o=0, dec_valid_o=0, offer not accepted.
REQ-047 Force stall_cnt_o near 0xFFFFFFFF and stall -> value holds at 0xFFFFFFFF.
REQ-048 Assert rst_i mid-stream -> all outputs reach reset values at the next edge.

Source files
------------

// File: rtl/kamus_pkg.sv
// Shared decode types for the kamus ID stage: operation and CSR enums,
// opcode/funct constants, the decoded bundle and the queue entry layout.
package kamus_pkg;

    // Decoded pc fields are carried at this width; narrower PCs are zero-extended.
    localparam int unsigned PcWidthMax = 32;

    localparam logic [6:0] OpcLui     = 7'b0110111;
    localparam logic [6:0] OpcAuipc   = 7'b0010111;
    localparam logic [6:0] OpcJal     = 7'b1101111;
    localparam logic [6:0] OpcJalr    = 7'b1100111;
    localparam logic [6:0] OpcBranch  = 7'b1100011;
    localparam logic [6:0] OpcLoad    = 7'b0000011;
    localparam logic [6:0] OpcStore   = 7'b0100011;
    localparam logic [6:0] OpcOpImm   = 7'b0010011;
    localparam logic [6:0] OpcOp      = 7'b0110011;
    localparam logic [6:0] OpcMiscMem = 7'b0001111;
    localparam logic [6:0] OpcSystem  = 7'b1110011;

    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;

    // OpInvalid is encoding 0 so an all-zero bundle reads as "nothing decoded".
    typedef enum logic [5:0] {
        OpInvalid,
        OpLui, OpAuipc, OpJal, OpJalr,
        OpBeq, OpBne, OpBlt, OpBge, OpBltu, OpBgeu,
        OpLb, OpLh, OpLw, OpLbu, OpLhu,
        OpSb, OpSh, OpSw,
        OpAddi, OpSlti, OpSltiu, OpXori, OpOri, OpAndi, OpSlli, OpSrli, OpSrai,
        OpAdd, OpSub, OpSll, OpSlt, OpSltu, OpXor, OpSrl, OpSra, OpOr, OpAnd,
        OpFence, OpEcall, OpEbreak, OpMret, OpWfi,
        OpCsrrw, OpCsrrs, OpCsrrc, OpCsrrwi, OpCsrrsi, OpCsrrci
    } operation_e;

    typedef enum logic [11:0] {
        CsrMstatus  = 12'h300,
        CsrMisa     = 12'h301,
        CsrMie      = 12'h304,
        CsrMtvec    = 12'h305,
        CsrMscratch = 12'h340,
        CsrMepc     = 12'h341,
        CsrMcause   = 12'h342,
        CsrMtval    = 12'h343,
        CsrMip      = 12'h344,
        CsrCycle    = 12'hC00,
        CsrTime     = 12'hC01,
        CsrInstret  = 12'hC02,
        CsrCycleh   = 12'hC80,
        CsrTimeh    = 12'hC81,
        CsrInstreth = 12'hC82,
        CsrMhartid  = 12'hF14
    } csr_e;

    typedef struct packed {
        operation_e  operation;
        logic [6:0]  opcode;
        logic [31:0] immediate;
        logic        immediate_used;
        logic [31:0] pc;
        logic [31:0] next_pc;
        logic        illegal;
    } instr_decoded_t;

    typedef struct packed {
        instr_decoded_t dec;
        logic [4:0]     rs1;
        logic [4:0]     rs2;
        logic [4:0]     rd;
        logic           is_load;
    } queue_entry_t;

    // User counters are always visible; machine CSRs only with machine mode enabled.
    function automatic logic csr_legal(input logic [11:0] addr, input logic mmode);
        logic ok;
        case (addr)
            CsrCycle, CsrTime, CsrInstret, CsrCycleh, CsrTimeh, CsrInstreth: ok = 1'b1;
            CsrMstatus, CsrMisa, CsrMie, CsrMtvec, CsrMscratch, CsrMepc, CsrMcause,
            CsrMtval, CsrMip, CsrMhartid: ok = mmode;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/kamus_id_stage_if.sv
// IF->ID offer handshake and ID->EX decoded-head handshake.
interface kamus_id_stage_if
    import kamus_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 32
);
    logic                instr_valid_i;
    logic                instr_ready_o;
    logic [31:0]         instr_i;
    logic [PC_WIDTH-1:0] instr_addr_i;
    logic [PC_WIDTH-1:0] next_pc_i;
    logic                dec_valid_o;
    logic                dec_ready_i;
    instr_decoded_t      dec_o;

    // Environment side: drives fetch offers and the EX consume strobe.
    modport master (
        output instr_valid_i, instr_i, instr_addr_i, next_pc_i, dec_ready_i,
        input  instr_ready_o, dec_valid_o, dec_o
    );

    // ID stage side.
    modport slave (
        input  instr_valid_i, instr_i, instr_addr_i, next_pc_i, dec_ready_i,
        output instr_ready_o, dec_valid_o, dec_o
    );
endinterface

// File: rtl/kamus_id_decoder.sv
// Purely combinational RV32I + Zicsr decoder: operation, immediate,
// register-usage flags and load detection.
module kamus_id_decoder
    import kamus_pkg::*;
#(
    parameter bit MACHINE_MODE_EN = 1'b0
) (
    input  logic [31:0] instr,
    output operation_e  operation,
    output logic [31:0] immediate,
    output logic        immediate_used,
    output logic        use_rs1,
    output logic        use_rs2,
    output logic        is_load
);
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        csr_ok;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign csr_ok = csr_legal(instr[31:20], MACHINE_MODE_EN);

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_z = {27'b0, instr[19:15]};

    // Operation and immediate selection; an invalid result never reports an immediate.
    always_comb begin
        operation      = OpInvalid;
        immediate      = '0;
        immediate_used = 1'b0;
        if (instr[1:0] == 2'b11) begin
            case (opcode)
                OpcLui:   begin operation = OpLui;   immediate = imm_u; immediate_used = 1'b1; end
                OpcAuipc: begin operation = OpAuipc; immediate = imm_u; immediate_used = 1'b1; end
                OpcJal:   begin operation = OpJal;   immediate = imm_j; immediate_used = 1'b1; end
                OpcJalr: begin
                    immediate = imm_i; immediate_used = 1'b1;
                    if (funct3 == 3'b000) operation = OpJalr;
                end
                OpcBranch: begin
                    immediate = imm_b; immediate_used = 1'b1;
                    case (funct3)
                        3'b000:  operation = OpBeq;
                        3'b001:  operation = OpBne;
                        3'b100:  operation = OpBlt;
                        3'b101:  operation = OpBge;
                        3'b110:  operation = OpBltu;
                        3'b111:  operation = OpBgeu;
                        default: operation = OpInvalid;
                    endcase
                end
                OpcLoad: begin
                    immediate = imm_i; immediate_used = 1'b1;
                    case (funct3)
                        3'b000:  operation = OpLb;
                        3'b001:  operation = OpLh;
                        3'b010:  operation = OpLw;
                        3'b100:  operation = OpLbu;
                        3'b101:  operation = OpLhu;
                        default: operation = OpInvalid;
                    endcase
                end
                OpcStore: begin
                    immediate = imm_s; immediate_used = 1'b1;
                    case (funct3)
                        3'b000:  operation = OpSb;
                        3'b001:  operation = OpSh;
                        3'b010:  operation = OpSw;
                        default: operation = OpInvalid;
                    endcase
                end
                OpcOpImm: begin
                    immediate = imm_i; immediate_used = 1'b1;
                    case (funct3)
                        3'b000:  operation = OpAddi;
                        3'b010:  operation = OpSlti;
                        3'b011:  operation = OpSltiu;
                        3'b100:  operation = OpXori;
                        3'b110:  operation = OpOri;
                        3'b111:  operation = OpAndi;
                        3'b001:  if (funct7 == F7Base) operation = OpSlli;
                        3'b101: begin
                            if (funct7 == F7Base) operation = OpSrli;
                            else if (funct7 == F7Alt) operation = OpSrai;
                        end
                        default: operation = OpInvalid;
                    endcase
                end
                OpcOp: begin
                    case ({funct7, funct3})
                        {F7Base, 3'b000}: operation = OpAdd;
                        {F7Alt,  3'b000}: operation = OpSub;
                        {F7Base, 3'b001}: operation = OpSll;
                        {F7Base, 3'b010}: operation = OpSlt;
                        {F7Base, 3'b011}: operation = OpSltu;
                        {F7Base, 3'b100}: operation = OpXor;
                        {F7Base, 3'b101}: operation = OpSrl;
                        {F7Alt,  3'b101}: operation = OpSra;
                        {F7Base, 3'b110}: operation = OpOr;
                        {F7Base, 3'b111}: operation = OpAnd;
                        default:          operation = OpInvalid;
                    endcase
                end
                OpcMiscMem: if (funct3 == 3'b000) operation = OpFence;
                OpcSystem: begin
                    case (funct3)
                        3'b000: begin
                            if (instr[19:7] == 13'b0) begin
                                case (instr[31:20])
                                    12'h000: operation = OpEcall;
                                    12'h001: operation = OpEbreak;
                                    12'h302: if (MACHINE_MODE_EN) operation = OpMret;
                                    12'h105: if (MACHINE_MODE_EN) operation = OpWfi;
                                    default: operation = OpInvalid;
                                endcase
                            end
                        end
                        3'b001: if (csr_ok) operation = OpCsrrw;
                        3'b010: if (csr_ok) operation = OpCsrrs;
                        3'b011: if (csr_ok) operation = OpCsrrc;
                        3'b101: if (csr_ok) operation = OpCsrrwi;
                        3'b110: if (csr_ok) operation = OpCsrrsi;
                        3'b111: if (csr_ok) operation = OpCsrrci;
                        default: operation = OpInvalid;
                    endcase
                    if (funct3[2]) begin
                        immediate      = imm_z;
                        immediate_used = 1'b1;
                    end
                end
                default: operation = OpInvalid;
            endcase
        end
        if (operation == OpInvalid) begin
            immediate      = '0;
            immediate_used = 1'b0;
        end
    end

    assign use_rs1 = !(operation inside {OpLui, OpAuipc, OpJal, OpCsrrwi, OpCsrrsi, OpCsrrci});
    assign use_rs2 = (operation != OpInvalid) &&
                     (opcode == OpcBranch || opcode == OpcStore || opcode == OpcOp);
    assign is_load = operation inside {OpLb, OpLh, OpLw, OpLbu, OpLhu};

endmodule

// File: rtl/kamus_id_stage.sv
// Decode stage: decodes the IF offer, holds decoded entries in a small FIFO
// toward EX, and stalls fetch on load-use hazards.
module kamus_id_stage
    import kamus_pkg::*;
#(
    parameter int unsigned PC_WIDTH        = 32,
    parameter int unsigned DEPTH           = 2,
    parameter bit          MACHINE_MODE_EN = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    kamus_id_stage_if.slave            id_if,
    input  logic                       ex_load_valid_i,
    input  logic [4:0]                 ex_load_rd_i,
    output logic [4:0]                 rs1_addr_o,
    output logic [4:0]                 rs2_addr_o,
    output logic [4:0]                 rd_addr_o,
    output logic [31:0]                stall_cnt_o,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    queue_entry_t    mem_q [DEPTH];
    logic [DEPTH-1:0] slot_valid_q;
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic [31:0]     stall_cnt_q;

    operation_e   operation;
    logic [31:0]  immediate;
    logic         immediate_used, use_rs1, use_rs2, is_load;
    logic [4:0]   in_rs1, in_rs2;
    logic         full, hazard, push, pop;
    queue_entry_t new_entry, head;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    kamus_id_decoder #(
        .MACHINE_MODE_EN(MACHINE_MODE_EN)
    ) u_decoder (
        .instr         (id_if.instr_i),
        .operation     (operation),
        .immediate     (immediate),
        .immediate_used(immediate_used),
        .use_rs1       (use_rs1),
        .use_rs2       (use_rs2),
        .is_load       (is_load)
    );

    assign in_rs1 = id_if.instr_i[19:15];
    assign in_rs2 = id_if.instr_i[24:20];

    // Assemble the queue entry for the current offer.
    always_comb begin
        new_entry                    = '0;
        new_entry.dec.operation      = operation;
        new_entry.dec.opcode         = id_if.instr_i[6:0];
        new_entry.dec.immediate      = immediate;
        new_entry.dec.immediate_used = immediate_used;
        new_entry.dec.pc             = PcWidthMax'(id_if.instr_addr_i);
        new_entry.dec.next_pc        = PcWidthMax'(id_if.next_pc_i);
        new_entry.dec.illegal        = (operation == OpInvalid);
        new_entry.rs1                = in_rs1;
        new_entry.rs2                = in_rs2;
        new_entry.rd                 = id_if.instr_i[11:7];
        new_entry.is_load            = is_load;
    end

    // Load-use hazard: a read source matches the load in EX or any queued load.
    always_comb begin
        hazard = 1'b0;
        if (use_rs1 && in_rs1 != 5'd0 && ex_load_valid_i && ex_load_rd_i == in_rs1) hazard = 1'b1;
        if (use_rs2 && in_rs2 != 5'd0 && ex_load_valid_i && ex_load_rd_i == in_rs2) hazard = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (slot_valid_q[i] && mem_q[i].is_load) begin
                if (use_rs1 && in_rs1 != 5'd0 && mem_q[i].rd == in_rs1) hazard = 1'b1;
                if (use_rs2 && in_rs2 != 5'd0 && mem_q[i].rd == in_rs2) hazard = 1'b1;
            end
        end
    end

    // Ready is built only from local state so dec_ready_i never reaches it combinationally.
    assign full                = (count_q == CntW'(DEPTH));
    assign id_if.instr_ready_o = !rst_i && !flush_i && !full && !hazard;
    assign id_if.dec_valid_o   = !rst_i && (count_q != '0);
    assign push                = id_if.instr_valid_i && id_if.instr_ready_o;
    assign pop                 = id_if.dec_valid_o && id_if.dec_ready_i;

    // Queue control: reset and flush override any push or pop.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            slot_valid_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q               <= ptr_inc(wr_ptr_q);
                slot_valid_q[wr_ptr_q] <= 1'b1;
            end
            if (pop) begin
                rd_ptr_q               <= ptr_inc(rd_ptr_q);
                slot_valid_q[rd_ptr_q] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents are qualified by slot_valid_q so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= new_entry;
    end

    // Saturating hazard-stall counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (id_if.instr_valid_i && hazard && !flush_i && stall_cnt_q != '1) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign head        = id_if.dec_valid_o ? mem_q[rd_ptr_q] : '0;
    assign id_if.dec_o = head.dec;
    assign rs1_addr_o  = head.rs1;
    assign rs2_addr_o  = head.rs2;
    assign rd_addr_o   = head.rd;
    assign stall_cnt_o = stall_cnt_q;
    assign occupancy_o = count_q;

endmodule

// File: tb/tb_kamus_id_stage.sv
// Directed bench for kamus_id_stage: decode, FIFO ordering, hazards, flush,
// stall-counter saturation and reset.
module tb_kamus_id_stage;
    import kamus_pkg::*;

    localparam logic [31:0] InsAdd  = 32'h002081B3; // add  x3,x1,x2
    localparam logic [31:0] InsLui  = 32'h123450B7; // lui  x1,0x12345
    localparam logic [31:0] InsLw   = 32'h0000A283; // lw   x5,0(x1)
    localparam logic [31:0] InsAddi = 32'h00128313; // addi x6,x5,1
    localparam logic [31:0] InsNop  = 32'h00000013; // addi x0,x0,0

    logic        clk = 1'b0;
    logic        rst, flush, ex_lv;
    logic [4:0]  ex_rd, rs1_addr, rs2_addr, rd_addr;
    logic [31:0] stall_cnt;
    logic [1:0]  occ;
    int          n_asserts = 0;
    int          n_fail    = 0;

    kamus_id_stage_if #(.PC_WIDTH(32)) id_if ();

    kamus_id_stage #(
        .PC_WIDTH       (32),
        .DEPTH          (2),
        .MACHINE_MODE_EN(1'b0)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .id_if          (id_if),
        .ex_load_valid_i(ex_lv),
        .ex_load_rd_i   (ex_rd),
        .rs1_addr_o     (rs1_addr),
        .rs2_addr_o     (rs2_addr),
        .rd_addr_o      (rd_addr),
        .stall_cnt_o    (stall_cnt),
        .occupancy_o    (occ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
        id_if.instr_valid_i = 1'b1;
        id_if.instr_i       = ins;
        id_if.instr_addr_i  = pc;
        id_if.next_pc_i     = pc + 32'd4;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; ex_lv = 1'b0; ex_rd = 5'd0;
        id_if.dec_ready_i = 1'b0;
        offer(InsAdd, 32'h80);
        #1;
        chk("rst_ready", 128'(id_if.instr_ready_o), 128'(0));
        tick(); tick();
        rst = 1'b0; id_if.instr_valid_i = 1'b0;
        #1;
        chk("rst_occ", 128'(occ), 128'(0));
        chk("rst_dec_valid", 128'(id_if.dec_valid_o), 128'(0));
        chk("rst_stall", 128'(stall_cnt), 128'(0));
        chk("rst_dec_zero", 128'(id_if.dec_o), 128'(0));

        // ADD x3,x1,x2 appears one cycle after acceptance
        offer(InsAdd, 32'h100);
        #1;
        chk("add_ready", 128'(id_if.instr_ready_o), 128'(1));
        tick();
        id_if.instr_valid_i = 1'b0;
        #1;
        chk("add_valid", 128'(id_if.dec_valid_o), 128'(1));
        chk("add_op", 128'(id_if.dec_o.operation), 128'(OpAdd));
        chk("add_rs1", 128'(rs1_addr), 128'(1));
        chk("add_rs2", 128'(rs2_addr), 128'(2));
        chk("add_rd", 128'(rd_addr), 128'(3));
        chk("add_imm_used", 128'(id_if.dec_o.immediate_used), 128'(0));
        chk("add_pc", 128'(id_if.dec_o.pc), 128'(32'h100));
        chk("add_next_pc", 128'(id_if.dec_o.next_pc), 128'(32'h104));
        chk("add_illegal", 128'(id_if.dec_o.illegal), 128'(0));

        // LUI pushed while ADD pops: occupancy stays at 1
        offer(InsLui, 32'h104);
        id_if.dec_ready_i = 1'b1;
        tick();
        chk("lui_op", 128'(id_if.dec_o.operation), 128'(OpLui));
        chk("lui_imm", 128'(id_if.dec_o.immediate), 128'(32'h12345000));
        chk("lui_imm_used", 128'(id_if.dec_o.immediate_used), 128'(1));
        chk("lui_occ", 128'(occ), 128'(1));

        offer(32'h0, 32'h108);
        tick();
        chk("zero_illegal", 128'(id_if.dec_o.illegal), 128'(1));
        chk("zero_op", 128'(id_if.dec_o.operation), 128'(OpInvalid));
        chk("zero_occ", 128'(occ), 128'(1));

        id_if.instr_valid_i = 1'b0;
        tick();
        id_if.dec_ready_i = 1'b0;
        #1;
        chk("empty_occ", 128'(occ), 128'(0));
        chk("empty_dec_zero", 128'(id_if.dec_o), 128'(0));
        chk("empty_rs1", 128'(rs1_addr), 128'(0));

        // Load-use hazard against a queued LW x5
        offer(InsLw, 32'h10C);
        tick();
        offer(InsAddi, 32'h110);
        #1;
        chk("haz_ready", 128'(id_if.instr_ready_o), 128'(0));
        chk("haz_stall0", 128'(stall_cnt), 128'(0));
        tick();
        chk("haz_stall1", 128'(stall_cnt), 128'(1));
        chk("haz_occ", 128'(occ), 128'(1));
        tick();
        chk("haz_stall2", 128'(stall_cnt), 128'(2));
        id_if.dec_ready_i = 1'b1;
        tick();
        id_if.dec_ready_i = 1'b0;
        #1;
        chk("haz_pop_occ", 128'(occ), 128'(0));
        chk("haz_clear_ready", 128'(id_if.instr_ready_o), 128'(1));
        tick();
        id_if.instr_valid_i = 1'b0;
        #1;
        chk("addi_op", 128'(id_if.dec_o.operation), 128'(OpAddi));
        chk("addi_rs1", 128'(rs1_addr), 128'(5));
        chk("addi_rd", 128'(rd_addr), 128'(6));
        chk("addi_imm", 128'(id_if.dec_o.immediate), 128'(32'd1));
        chk("addi_stall", 128'(stall_cnt), 128'(3));

        // Hazard against the load currently in EX (rs2 = x2)
        offer(InsAdd, 32'h114);
        ex_lv = 1'b1; ex_rd = 5'd2;
        #1;
        chk("ex_haz_ready", 128'(id_if.instr_ready_o), 128'(0));
        ex_rd = 5'd7;
        #1;
        chk("ex_nohaz_ready", 128'(id_if.instr_ready_o), 128'(1));
        id_if.instr_valid_i = 1'b0; ex_lv = 1'b0;
        id_if.dec_ready_i = 1'b1;
        tick();
        id_if.dec_ready_i = 1'b0;
        #1;
        chk("drain_occ", 128'(occ), 128'(0));

        // Full queue holds the third offer; a pop frees a slot next cycle
        offer(InsAdd, 32'h200);
        tick();
        offer(InsLui, 32'h204);
        tick();
        offer(InsNop, 32'h208);
        #1;
        chk("full_ready", 128'(id_if.instr_ready_o), 128'(0));
        chk("full_occ", 128'(occ), 128'(2));
        chk("full_head", 128'(id_if.dec_o.pc), 128'(32'h200));
        tick();
        chk("full_no_stall", 128'(stall_cnt), 128'(3));
        id_if.dec_ready_i = 1'b1;
        #1;
        chk("full_ready_indep", 128'(id_if.instr_ready_o), 128'(0));
        tick();
        id_if.dec_ready_i = 1'b0;
        #1;
        chk("after_pop_occ", 128'(occ), 128'(1));
        chk("after_pop_ready", 128'(id_if.instr_ready_o), 128'(1));
        chk("after_pop_head", 128'(id_if.dec_o.pc), 128'(32'h204));
        tick();
        id_if.instr_valid_i = 1'b0;
        #1;
        chk("third_occ", 128'(occ), 128'(2));
        id_if.dec_ready_i = 1'b1;
        tick();
        id_if.dec_ready_i = 1'b0;
        #1;
        chk("order_head", 128'(id_if.dec_o.pc), 128'(32'h208));
        chk("order_op", 128'(id_if.dec_o.operation), 128'(OpAddi));

        // Flush with a live offer and a pop request
        offer(InsAdd, 32'h20C);
        tick();
        chk("pre_flush_occ", 128'(occ), 128'(2));
        flush = 1'b1; id_if.dec_ready_i = 1'b1;
        offer(InsLw, 32'h210);
        #1;
        chk("flush_ready", 128'(id_if.instr_ready_o), 128'(0));
        tick();
        flush = 1'b0; id_if.instr_valid_i = 1'b0; id_if.dec_ready_i = 1'b0;
        #1;
        chk("flush_occ", 128'(occ), 128'(0));
        chk("flush_dec_valid", 128'(id_if.dec_valid_o), 128'(0));
        chk("flush_pc", 128'(id_if.dec_o.pc), 128'(0));

        // A hazard during flush is not counted
        flush = 1'b1; ex_lv = 1'b1; ex_rd = 5'd1;
        offer(InsAdd, 32'h214);
        tick();
        flush = 1'b0;
        chk("flush_haz_stall", 128'(stall_cnt), 128'(3));

        // Saturation: preload the counter close to its limit, then keep stalling
        force dut.stall_cnt_q = 32'hFFFF_FFFD;
        #1;
        release dut.stall_cnt_q;
        #1;
        chk("sat_preload", 128'(stall_cnt), 128'(32'hFFFF_FFFD));
        tick();
        chk("sat_fe", 128'(stall_cnt), 128'(32'hFFFF_FFFE));
        tick();
        chk("sat_ff", 128'(stall_cnt), 128'(32'hFFFF_FFFF));
        tick();
        chk("sat_hold", 128'(stall_cnt), 128'(32'hFFFF_FFFF));
        id_if.instr_valid_i = 1'b0; ex_lv = 1'b0;

        // Reset mid-stream discards queued entries
        offer(InsAdd, 32'h300);
        tick();
        offer(InsLui, 32'h304);
        tick();
        chk("pre_rst_occ", 128'(occ), 128'(2));
        rst = 1'b1; id_if.dec_ready_i = 1'b1;
        offer(InsNop, 32'h308);
        #1;
        chk("mid_rst_ready", 128'(id_if.instr_ready_o), 128'(0));
        chk("mid_rst_dec_valid", 128'(id_if.dec_valid_o), 128'(0));
        tick();
        chk("post_rst_occ", 128'(occ), 128'(0));
        chk("post_rst_stall", 128'(stall_cnt), 128'(0));
        rst = 1'b0; id_if.instr_valid_i = 1'b0; id_if.dec_ready_i = 1'b0;
        tick();
        chk("post_rst_valid", 128'(id_if.dec_valid_o), 128'(0));
        chk("post_rst_dec_zero", 128'(id_if.dec_o), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
